// File: rtl/rop3_pkg.sv
// Shared definitions for the ROP3 raster-operation unit and its stream feeder.
package rop3_pkg;

    // ROP3 mode codes understood by the ROP3 unit.
    localparam logic [7:0] ROP_BLACKNESS   = 8'h00;
    localparam logic [7:0] ROP_NOTSRCERASE = 8'h11;
    localparam logic [7:0] ROP_NOTSRCCOPY  = 8'h33;
    localparam logic [7:0] ROP_SRCERASE    = 8'h44;
    localparam logic [7:0] ROP_DSTINVERT   = 8'h55;
    localparam logic [7:0] ROP_PATINVERT   = 8'h5A;
    localparam logic [7:0] ROP_SRCINVERT   = 8'h66;
    localparam logic [7:0] ROP_SRCAND      = 8'h88;
    localparam logic [7:0] ROP_MERGEPAINT  = 8'hBB;
    localparam logic [7:0] ROP_MERGECOPY   = 8'hC0;
    localparam logic [7:0] ROP_SRCCOPY     = 8'hCC;
    localparam logic [7:0] ROP_SRCPAINT    = 8'hEE;
    localparam logic [7:0] ROP_PATCOPY     = 8'hF0;
    localparam logic [7:0] ROP_PATPAINT    = 8'hFB;
    localparam logic [7:0] ROP_WHITENESS   = 8'hFF;

    // Fixed pipeline latency of the ROP3 unit (input register + result register).
    localparam int ROP_LAT = 2;

    // Feeder control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

    // True for mode codes the ROP3 unit implements; others produce 0.
    function automatic logic rop3_mode_supported(input logic [7:0] mode);
        case (mode)
            ROP_BLACKNESS, ROP_NOTSRCERASE, ROP_NOTSRCCOPY, ROP_SRCERASE,
            ROP_DSTINVERT, ROP_PATINVERT, ROP_SRCINVERT, ROP_SRCAND,
            ROP_MERGEPAINT, ROP_MERGECOPY, ROP_SRCCOPY, ROP_SRCPAINT,
            ROP_PATCOPY, ROP_PATPAINT, ROP_WHITENESS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rop3_fifo.sv
// Fall-through FIFO: the head entry is visible on dout whenever not empty.
// dout reads as zero while empty so downstream sees clean data after reset.
module rop3_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Read/write pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rop3_stream_feeder.sv
// Front end for the ROP3 unit: joins S/D streams under a command, drives the
// unit one word per cycle, tracks its 2-cycle latency and buffers results.
// The ROP3 unit cannot stall, so issue is throttled by output-FIFO credits.
module rop3_stream_feeder
    import rop3_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_mode,
    input  logic [N-1:0]     cmd_pat,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [N-1:0]     src_data,
    input  logic             dst_valid,
    output logic             dst_ready,
    input  logic [N-1:0]     dst_data,
    output logic [N-1:0]     rop_p,
    output logic [N-1:0]     rop_s,
    output logic [N-1:0]     rop_d,
    output logic [7:0]       rop_mode,
    input  logic [N-1:0]     rop_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SUM_W = CW + 1;

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic [7:0]       mode_q;
    logic [N-1:0]     pat_q;
    logic [CNT_W-1:0] remaining;

    // Valid/last pipeline shadowing the ROP3 unit's two internal registers.
    logic             vld_p1;
    logic             last_p1;
    logic             vld_p2;
    logic             last_p2;

    logic             done_q;
    logic             accept;
    logic             done_next;
    logic             credit_ok;
    logic             issue;
    logic             pop;
    logic [SUM_W-1:0] inflight;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic [N:0]       fifo_head;

    // Every word between the ROP3 inputs and the FIFO output holds one credit.
    assign inflight  = SUM_W'(vld_p1) + SUM_W'(vld_p2) + SUM_W'(fifo_count);
    assign credit_ok = (inflight < SUM_W'(DEPTH));

    // S and D are taken only as a pair, so each ready depends on the other valid.
    assign issue     = (state == RUN) && src_valid && dst_valid && credit_ok;
    assign src_ready = (state == RUN) && dst_valid && credit_ok;
    assign dst_ready = (state == RUN) && src_valid && credit_ok;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;

    // Mode and pattern stay on the ROP3 inputs while any word is in flight.
    assign rop_p     = busy  ? pat_q    : '0;
    assign rop_mode  = busy  ? mode_q   : '0;
    assign rop_s     = issue ? src_data : '0;
    assign rop_d     = issue ? dst_data : '0;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[N:1];
    assign out_last  = fifo_head[0];
    assign pop       = out_valid && out_ready;

    // Next-state and command-completion decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (issue && (remaining == CNT_W'(1))) state_next = DRAIN;
            end
            DRAIN: begin
                // The last word leaving the FIFO means nothing else is in flight.
                if (pop && out_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Word counter, completion pulse and the valid/last pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            done_q    <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
        end else begin
            done_q <= done_next;
            if (accept)     remaining <= cmd_len;
            else if (issue) remaining <= remaining - CNT_W'(1);
            // stage 1: word captured by the ROP3 input registers
            vld_p1  <= issue;
            last_p1 <= issue && (remaining == CNT_W'(1));
            // stage 2: word captured by the ROP3 result register
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    // Command operands are latched on acceptance; output gating covers reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q <= cmd_mode;
            pat_q  <= cmd_pat;
        end
    end

    rop3_fifo #(
        .W     (N + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p2),
        .din   ({rop_result, last_p2}),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_rop3_stream_feeder.sv
// Bench for rop3_stream_feeder with a behavioural ROP3 unit and a result scoreboard.
module tb_rop3_stream_feeder;

    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_mode;
    logic [N-1:0]     cmd_pat;
    logic [CNT_W-1:0] cmd_len;
    logic             src_valid;
    logic             src_ready;
    logic [N-1:0]     src_data;
    logic             dst_valid;
    logic             dst_ready;
    logic [N-1:0]     dst_data;
    logic [N-1:0]     rop_p;
    logic [N-1:0]     rop_s;
    logic [N-1:0]     rop_d;
    logic [7:0]       rop_mode;
    logic [N-1:0]     rop_result;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int rise_cyc = 0;
    int last_hs_cyc = 0;

    logic [N:0] exp_q[$];
    logic [N-1:0] s_arr [16];
    logic [N-1:0] d_arr [16];

    rop3_stream_feeder #(.N(N), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_pat(cmd_pat), .cmd_len(cmd_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
        .rop_p(rop_p), .rop_s(rop_s), .rop_d(rop_d), .rop_mode(rop_mode),
        .rop_result(rop_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    // Behavioural ROP3 unit: bit i of the result is mode[{P[i],S[i],D[i]}] for supported codes.
    function automatic logic [N-1:0] rop3_fn(input logic [7:0] m, input logic [N-1:0] p,
                                            input logic [N-1:0] s, input logic [N-1:0] d);
        logic [N-1:0] r;
        r = '0;
        case (m)
            8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
            8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF: begin
                for (int i = 0; i < N; i++) r[i] = m[{p[i], s[i], d[i]}];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [N-1:0] r_p, r_s, r_d;
    logic [7:0]   r_m;
    always @(posedge clk) begin
        r_p        <= rop_p;
        r_s        <= rop_s;
        r_d        <= rop_d;
        r_m        <= rop_mode;
        rop_result <= rop3_fn(r_m, r_p, r_s, r_d);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [N-1:0] data, input logic last);
        exp_q.push_back({data, last});
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : monitor
        logic prev_ov;
        logic [N:0] e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_ov) rise_cyc = cycle;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("FAIL unexpected_out: got %0h last %0b expected no word", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_word", {23'd0, out_data, out_last}, {23'd0, e});
                    end
                    if (out_last) last_hs_cyc = cycle;
                end
                prev_ov = out_valid;
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic [7:0] m, input logic [N-1:0] p, input logic [CNT_W-1:0] l);
        bit acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_pat   = p;
        cmd_len   = l;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(acc), 32'd1);
    endtask

    // Offers words [first, stop) and returns how many were consumed jointly.
    task automatic feed(input int first, input int stop, input bit skew, input int budget,
                        output int got, output int first_cyc);
        int  idx;
        int  n;
        bit  sfire;
        bit  dfire;
        idx = first;
        n = 0;
        first_cyc = -1;
        while (idx < stop && n < budget) begin
            src_valid = skew ? (n[0] == 1'b0) : 1'b1;
            dst_valid = 1'b1;
            src_data  = s_arr[idx];
            dst_data  = d_arr[idx];
            @(negedge clk);
            sfire = src_valid && src_ready;
            dfire = dst_valid && dst_ready;
            chk("joint_consume", 32'(sfire), 32'(dfire));
            if (sfire && dfire) begin
                if (first_cyc < 0) first_cyc = cycle;
                idx++;
            end
            n++;
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
        dst_valid = 1'b0;
        got = idx;
    endtask

    task automatic wait_done(input int budget, output int dc);
        bit found;
        found = 1'b0;
        dc = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                dc = cycle;
            end
            @(posedge clk); #1;
        end
        if (!found) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    initial begin : stim
        int got;
        int fc;
        int dc;
        bit any;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_pat = '0; cmd_len = '0;
        src_valid = 1'b0; src_data = '0;
        dst_valid = 1'b0; dst_data = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_dst_ready", 32'(dst_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_rop_pmode", {16'd0, rop_p, rop_mode}, 32'd0);
        chk("rst_rop_sd",    {16'd0, rop_s, rop_d},    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SRCINVERT, 3 words: 0F^F0=FF, 33^33=00, FF^00=FF.
        s_arr[0] = 8'h0F; s_arr[1] = 8'h33; s_arr[2] = 8'hFF;
        d_arr[0] = 8'hF0; d_arr[1] = 8'h33; d_arr[2] = 8'h00;
        expect_word(8'hFF, 1'b0);
        expect_word(8'h00, 1'b0);
        expect_word(8'hFF, 1'b1);
        send_cmd(8'h66, 8'h00, 8'd3);
        chk("busy_run", 32'(busy), 32'd1);
        chk("cmd_ready_run", 32'(cmd_ready), 32'd0);
        feed(0, 3, 1'b0, 20, got, fc);
        chk("t1_issued", 32'(got), 32'd3);
        wait_done(40, dc);
        chk("t1_latency", 32'(rise_cyc - fc), 32'd3);
        chk("t1_done_timing", 32'(dc - last_hs_cyc), 32'd1);
        chk("t1_idle_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_busy_off", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // PATCOPY with pattern A5: four words of A5 whatever S/D are.
        for (int i = 0; i < 4; i++) begin
            s_arr[i] = 8'(8'h13 * i);
            d_arr[i] = 8'(8'h5C + i);
        end
        for (int i = 0; i < 4; i++) expect_word(8'hA5, i == 3);
        send_cmd(8'hF0, 8'hA5, 8'd4);
        feed(0, 4, 1'b0, 20, got, fc);
        chk("t2_issued", 32'(got), 32'd4);
        wait_done(40, dc);

        // Unsupported mode 0x12: the unit returns zero for each word.
        expect_word(8'h00, 1'b0);
        expect_word(8'h00, 1'b1);
        send_cmd(8'h12, 8'h3C, 8'd2);
        feed(0, 2, 1'b0, 20, got, fc);
        chk("t2b_issued", 32'(got), 32'd2);
        wait_done(40, dc);

        // Zero-length command: done next cycle, nothing consumed or produced.
        send_cmd(8'h88, 8'h00, 8'd0);
        src_valid = 1'b1;
        dst_valid = 1'b1;
        @(negedge clk);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_cmd_ready", 32'(cmd_ready), 32'd1);
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            any = any | src_ready | dst_ready | out_valid;
        end
        chk("t3_no_activity", 32'(any), 32'd0);
        @(posedge clk); #1;
        src_valid = 1'b0;
        dst_valid = 1'b0;

        // SRCCOPY, 10 words with out_ready low: credits stop issue at DEPTH.
        for (int i = 0; i < 10; i++) begin
            s_arr[i] = 8'(8'h40 + i);
            d_arr[i] = 8'h3C;
        end
        for (int i = 0; i < 10; i++) expect_word(8'(8'h40 + i), i == 9);
        out_ready = 1'b0;
        send_cmd(8'hCC, 8'h00, 8'd10);
        feed(0, 10, 1'b0, 12, got, fc);
        chk("t4_credit_stop", 32'(got), 32'd4);
        src_valid = 1'b1;
        dst_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready_low", {30'd0, src_ready, dst_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        feed(4, 10, 1'b0, 40, got, fc);
        chk("t4_issued", 32'(got), 32'd10);
        wait_done(40, dc);

        // Skewed streams: src_valid toggles, dst_valid steady; S^D pairs must line up.
        s_arr[0] = 8'h01; s_arr[1] = 8'h02; s_arr[2] = 8'h04; s_arr[3] = 8'h08; s_arr[4] = 8'h10;
        d_arr[0] = 8'hFF; d_arr[1] = 8'h00; d_arr[2] = 8'hF0; d_arr[3] = 8'h0F; d_arr[4] = 8'hAA;
        expect_word(8'hFE, 1'b0);
        expect_word(8'h02, 1'b0);
        expect_word(8'hF4, 1'b0);
        expect_word(8'h07, 1'b0);
        expect_word(8'hBA, 1'b1);
        send_cmd(8'h66, 8'h00, 8'd5);
        feed(0, 5, 1'b1, 40, got, fc);
        chk("t5_issued", 32'(got), 32'd5);
        wait_done(40, dc);

        // Reset with two words in flight and one buffered.
        for (int i = 0; i < 6; i++) begin
            s_arr[i] = 8'(8'h90 + i);
            d_arr[i] = 8'h00;
        end
        out_ready = 1'b0;
        send_cmd(8'hCC, 8'h00, 8'd6);
        feed(0, 3, 1'b0, 20, got, fc);
        chk("t6_pre_issued", 32'(got), 32'd3);
        chk("t6_pre_buffered", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_data",  {23'd0, out_data, out_last}, 32'd0);
        chk("t6_rst_busy",      32'(busy), 32'd0);
        chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rst_rop",       {rop_p, rop_mode, rop_s, rop_d}, 32'd0);
        chk("t6_rst_done",      32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        s_arr[0] = 8'h77;
        d_arr[0] = 8'h0F;
        expect_word(8'hF0, 1'b1);
        send_cmd(8'h55, 8'h00, 8'd1);
        feed(0, 1, 1'b0, 20, got, fc);
        chk("t6_issued", 32'(got), 32'd1);
        wait_done(40, dc);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rop3_stream_feeder.md
# rop3_stream_feeder

Front-end stage for the ROP3 raster-operation unit. It accepts a blit command (mode, pattern, word count) and two operand streams (source S, destination D). It drives the ROP3 unit's P/S/D/Mode inputs one word per cycle and tracks the unit's fixed 2-cycle latency with a valid pipeline. Returned results are buffered in a small output FIFO with valid/ready and last-word marking. Because the ROP3 unit cannot stall, backpressure is enforced with credits.

## Interface
Parameters:
- N, 8, data width of P/S/D/Result; must match the ROP3 unit
- CNT_W, 8, width of the command word count
- DEPTH, 4, output FIFO entries; power of 2; must be ≥4 for full throughput

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when both high
- cmd_mode  in  8  ROP3 mode code
- cmd_pat  in  N  pattern word (P), constant for whole command
- cmd_len  in  CNT_W  number of words; 0 is legal
- src_valid  in  1  S stream valid
- src_ready  out  1  S stream ready
- src_data  in  N  S word
- dst_valid  in  1  D stream valid
- dst_ready  out  1  D stream ready
- dst_data  in  N  D word
- rop_p  out  N  to ROP3 P input
- rop_s  out  N  to ROP3 S input
- rop_d  out  N  to ROP3 D input
- rop_mode  out  8  to ROP3 Mode input
- rop_result  in  N  from ROP3 Result output
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts
- out_data  out  N  result word
- out_last  out  1  marks final word of command
- busy  out  1  high in RUN or DRAIN
- done  out  1  1-cycle pulse at command completion

## Operation
- FSM with three states: IDLE, RUN, DRAIN.
- **IDLE**
  - cmd_ready=1. On cmd_valid, latch mode, pat and len.
  - len==0: stay in IDLE; done=1 the next cycle; no words consumed or produced.
  - len>0: go to RUN with remaining=len.
- **RUN**
  - An issue occurs when src_valid && dst_valid && credit_ok.
  - credit_ok = (v1 + v2 + fifo_count) < DEPTH.
  - src_ready = dst_valid && credit_ok; dst_ready = src_valid && credit_ok. S and D are always consumed together, never one without the other.
  - On issue: rop_s=src_data, rop_d=dst_data, v1 is set, l1 = (remaining==1), remaining is decremented.
  - After the issue with remaining==1, go to DRAIN.
- **DRAIN**
  - No issue.
  - Go to IDLE when v1, v2 and the FIFO are all empty, i.e. after the out_last handshake. done=1 in the following cycle.
- rop_p=latched pat and rop_mode=latched mode during RUN and DRAIN; both are 0 in IDLE. The mode is held stable while any word is in flight.
- rop_s and rop_d are don't-care when no issue occurs; the valid pipeline discards the corresponding results.
- Valid pipeline: (v1,l1) → (v2,l2) every cycle. When v2=1, {rop_result, l2} is pushed into the FIFO. Credits guarantee the push never overflows.
- The FIFO is fall-through: out_valid = !empty, and out_data/out_last are the head entry. It pops on out_valid && out_ready.
- The result word is exactly what the ROP3 unit produces, including 0 for unsupported modes. The feeder does not filter modes.
- busy = (state != IDLE).

## Timing
- Reset, asynchronous on rst_n low:
  - state=IDLE, remaining=0, v1=v2=0, FIFO empty.
  - cmd_ready=1, src_ready=dst_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - rop_p=rop_s=rop_d=0, rop_mode=0.
- Reset mid-command discards all in-flight and buffered words. The ROP3 unit has no reset; its stale output is ignored because v1 and v2 are cleared.
- Latency: an issue in cycle c gives out_valid in cycle c+3.
  - ROP3 input registers capture at the end of c; Result is captured at the end of c+1; the FIFO push happens at the end of c+2.
- Throughput: 1 word/cycle with out_ready held high and both streams valid (DEPTH=4).
- out_ready low: at most DEPTH words are issued, then src_ready and dst_ready drop until a pop frees a credit.
- A push and a pop in the same cycle are both honoured; the count is unchanged.
- Only one command is outstanding. cmd_ready=0 from acceptance of a len>0 command until the IDLE return. The next command can be accepted in the same cycle done is high.

## Structure
- Package rop3_pkg holds:
  - ROP3 mode code localparams (8'h00, 8'h11 … 8'hFF), shared with the ROP3 unit.
  - The feeder state enum typedef (IDLE/RUN/DRAIN).
  - ROP_LAT=2, the ROP3 pipeline latency.
- One sub-module: rop3_fifo, a parameterized N+1-bit-wide, DEPTH-entry fall-through FIFO with count output. It has asynchronous active-low reset.

## Test plan
- Mode 0x66, len=3, S={0x0F,0x33,0xFF}, D={0xF0,0x33,0x00}, out_ready=1:
  - out_data={0xFF,0x00,0xFF}
  - out_last only on the 3rd word
  - first out_valid 3 cycles after the first issue
  - done one cycle after the last handshake
- Mode 0xF0, pat=0xA5, len=4, any S/D -> four words of 0xA5. Mode 0x12 (unsupported), len=2 -> two words of 0x00.
- cmd_len=0 with mode 0x88 -> no src_ready/dst_ready pulse, no out_valid, done high the cycle after acceptance, cmd_ready stays 1.
- Mode 0xCC, len=10, out_ready=0:
  - exactly 4 words issued, then src_ready=dst_ready=0
  - after out_ready=1, all 10 words arrive in order, out_last on the 10th
- Skewed streams: src_valid toggling every cycle, dst_valid constant -> S and D are consumed only jointly; results are correctly paired; no word is lost.
- rst_n pulsed low while 2 words are in flight with 1 word buffered -> all outputs return to reset values immediately. A new len=1 command (mode 0x55, D=0x0F) then yields exactly one word 0xF0 with no stale data.
